mem_access: RTL and testbench

Data-memory access stage for the MIPS core, directly downstream of the ALU. It takes the effective address computed by the ALU for LW/SW and runs a request/acknowledge transaction to a word-wide data memory. It stalls the core until the access completes, then returns load data to write-back. Non-memory instructions pass through with no stall.

---
 rtl/mem_access.sv | 157 +++++++++++++++
 tb/tb_mem_access.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Data-memory access stage: LW/SW request/ack handshake with stall, timeout and load return.
// Optional misaligned-access trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        bus_err_q, bus_err_d;
  logic        is_mem;

  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign misalign = misalign_q;
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr[1:0];
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    bus_err_d     = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid && is_mem) begin
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = wdata;
          mem_we_d    = (opcode == OP_SW);
          cnt_d       = 8'd0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (addr[1:0] != 2'b00) begin
            state_d    = S_DONE;
            misalign_d = 1'b1;
            rdata_d    = 32'd0;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
`else
          state_d   = S_REQ;
          mem_req_d = 1'b1;
`endif
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d       = mem_rdata;
            rdata_valid_d = 1'b1;
          end
        end else if (!mem_req_q) begin
          // request already dropped last cycle: counter has hit the limit
          state_d   = S_DONE;
          bus_err_d = 1'b1;
          if (!mem_we_q) begin
            rdata_d       = 32'd0;
            rdata_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TO_LAST) mem_req_d = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      bus_err_q     <= bus_err_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign stall       = ((state_q == S_IDLE) && op_valid && is_mem) || (state_q == S_REQ);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign bus_err     = bus_err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access (TIMEOUT=4): expected bus requests and completion
// pulses are queued at issue time and checked by a separate monitor process.
module tb_mem_access;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  logic        clk, rst, op_valid;
  logic [5:0]  opcode;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, bus_err, misalign, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode), .addr(addr),
    .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .bus_err(bus_err), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct { logic we; logic [31:0] a; logic [31:0] d; } req_t;
  typedef struct { logic rv; logic [31:0] rd; logic be; logic mis; } resp_t;
  req_t  req_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad = 0;
  int ack_dly = -1;
  logic [31:0] mem_data = 32'd0;
  logic late_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // memory model: acks after ack_dly further request cycles (ack_dly<0: never)
  initial begin
    int req_cnt;
    req_cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req) req_cnt++; else req_cnt = 0;
      mem_ack = late_ack || (mem_req && ack_dly >= 0 && req_cnt == ack_dly + 1);
      mem_rdata = mem_data;
    end
  end

  // monitor
  initial begin
    logic  prev_req, have;
    req_t  cur;
    resp_t r;
    prev_req = 1'b0;
    have = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (mem_req) begin
        if (!prev_req) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
            have = 1'b0;
          end else begin
            cur = req_q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("mem_we", mem_we, cur.we);
          chk("mem_addr", mem_addr, cur.a);
          chk("mem_wdata", mem_wdata, cur.d);
        end
      end
      prev_req = mem_req;
      if (rdata_valid || bus_err || misalign) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, rdata_valid, bus_err, misalign}, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("rdata_valid", rdata_valid, r.rv);
          chk("rdata", rdata, r.rd);
          chk("bus_err", bus_err, r.be);
          chk("misalign", misalign, r.mis);
        end
      end
    end
  end

  task automatic run_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] wd,
                        input int dly, input logic [31:0] md, input int exp_stall, input int exp_req);
    int n_st, n_req;
    bit done;
    ack_dly = dly;
    mem_data = md;
    @(posedge clk); #1;
    op_valid = 1'b1; opcode = opc; addr = a; wdata = wd;
    n_st = 0; n_req = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (mem_req) n_req++;
      if (!stall) begin
        done = 1;
        break;
      end
      n_st++;
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    if (!done) chk("stall_bound", 32'd1, 32'd0);
    chk("stall_len", n_st, exp_stall);
    chk("req_len", n_req, exp_req);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; opcode = 6'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall", stall, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_buserr", bus_err, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW ack in first REQ cycle
    req_q.push_back('{1'b0, 32'h10, 32'hAAAA0000});
    resp_q.push_back('{1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
    run_op(LW, 32'h10, 32'hAAAA0000, 0, 32'hDEADBEEF, 2, 1);

    // SW with ack delayed 3 cycles
    req_q.push_back('{1'b1, 32'h20, 32'h12345678});
    run_op(SW, 32'h20, 32'h12345678, 3, 32'h55555555, 5, 4);
    chk("rdata_hold_sw", rdata, 32'hDEADBEEF);

    // non-memory op
    run_op(6'b001001, 32'h40, 32'h1, -1, 32'h0, 0, 0);

    // LW timeout
    req_q.push_back('{1'b0, 32'h30, 32'h0});
    resp_q.push_back('{1'b1, 32'h0, 1'b1, 1'b0});
    run_op(LW, 32'h30, 32'h0, -1, 32'h77777777, 6, 4);

    // LW ack on last allowed REQ cycle
    req_q.push_back('{1'b0, 32'h34, 32'h0});
    resp_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0, 1'b0});
    run_op(LW, 32'h34, 32'h0, 3, 32'hCAFEF00D, 5, 4);

    // SW timeout keeps rdata
    req_q.push_back('{1'b1, 32'h38, 32'h9ABCDEF0});
    resp_q.push_back('{1'b0, 32'hCAFEF00D, 1'b1, 1'b0});
    run_op(SW, 32'h38, 32'h9ABCDEF0, -1, 32'h0, 6, 4);

    // misaligned LW
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    resp_q.push_back('{1'b0, 32'h0, 1'b0, 1'b1});
    run_op(LW, 32'h13, 32'h0, 0, 32'h11112222, 1, 0);
`else
    req_q.push_back('{1'b0, 32'h10, 32'h0});
    resp_q.push_back('{1'b1, 32'h11112222, 1'b0, 1'b0});
    run_op(LW, 32'h13, 32'h0, 0, 32'h11112222, 2, 1);
`endif

    // reset during the second REQ cycle, then a stray ack
    ack_dly = -1;
    req_q.push_back('{1'b0, 32'h50, 32'h0});
    @(posedge clk); #1;
    op_valid = 1'b1; opcode = LW; addr = 32'h50; wdata = 32'h0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("req_before_rst", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_addr", mem_addr, 0);
    @(posedge clk); #1;
    late_ack = 1'b1;
    mem_data = 32'hFFFF0000;
    @(posedge clk); #1;
    late_ack = 1'b0;
    @(negedge clk); #1;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_stall", stall, 0);
    chk("late_ack_rdata", rdata, 0);

    // normal load after recovery
    req_q.push_back('{1'b0, 32'h60, 32'h0});
    resp_q.push_back('{1'b1, 32'h0BADCAFE, 1'b0, 1'b0});
    run_op(LW, 32'h60, 32'h0, 1, 32'h0BADCAFE, 3, 2);

    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("req_q_empty", req_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
